// File: rtl/s2_pkt_receiver.sv
// s2_pkt_receiver
// Deserialises 21-bit address/data packages arriving MSB first on the sen/sd
// link and turns every well-framed package into one RB2 write. Short or
// overlong packages are dropped with a single-cycle frame_err pulse. After
// NUM_PKT good packages the block parks in DONE until reset.
//
// RB2 write strobe: RB2_RW is low for exactly one clock per accepted package.
// RB2_A/RB2_D are valid during that clock and hold afterwards. There is no
// back-pressure, so RB2 must accept a write on any cycle.
//
// state_dbg and pkt_cnt_dbg expose the FSM state and the package counter so
// external checkers can observe them.
module s2_pkt_receiver #(
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 18,
    parameter int NUM_PKT = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sen,
    input  logic                         sd,
    output logic                         RB2_RW,
    output logic [ADDR_W-1:0]            RB2_A,
    output logic [DATA_W-1:0]            RB2_D,
    output logic                         frame_err,
    output logic                         done,
    output logic [1:0]                   state_dbg,
    output logic [$clog2(NUM_PKT+1)-1:0] pkt_cnt_dbg
);

    localparam int PKT_LEN   = ADDR_W + DATA_W;
    localparam int BIT_CNT_W = $clog2(PKT_LEN + 1);
    localparam int CNT_W     = $clog2(NUM_PKT + 1);

    localparam logic [BIT_CNT_W-1:0] LEN_VAL  = BIT_CNT_W'(PKT_LEN);
    localparam logic [BIT_CNT_W-1:0] ONE_BIT  = BIT_CNT_W'(1);
    localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(NUM_PKT - 1);
    localparam logic [CNT_W-1:0]     ONE_PKT  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_next;

    logic [PKT_LEN-1:0]     shreg;
    logic [PKT_LEN-1:0]     shreg_next;
    logic [PKT_LEN-1:0]     shreg_shifted;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [BIT_CNT_W-1:0]   bit_cnt_next;
    logic [CNT_W-1:0]       pkt_cnt;
    logic [CNT_W-1:0]       pkt_cnt_next;
    logic                   wr_en;
    logic                   err_next;
    logic                   last_pkt;

    // Shift register contents if the current sd sample is accepted.
    assign shreg_shifted = {shreg[PKT_LEN-2:0], sd};

    // The write about to be issued is the one that completes the batch.
    assign last_pkt = (pkt_cnt == LAST_CNT);

    assign state_dbg   = state;
    assign pkt_cnt_dbg = pkt_cnt;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, framing decisions and datapath next values.
    always_comb begin
        state_next   = state;
        shreg_next   = shreg;
        bit_cnt_next = bit_cnt;
        pkt_cnt_next = pkt_cnt;
        wr_en        = 1'b0;
        err_next     = 1'b0;

        case (state)
            ST_IDLE: begin
                // The first low sen sample already carries the address MSB.
                if (!sen) begin
                    shreg_next   = shreg_shifted;
                    bit_cnt_next = ONE_BIT;
                    state_next   = ST_RECV;
                end
            end

            ST_RECV: begin
                if (!sen) begin
                    if (bit_cnt == LEN_VAL) begin
                        // A 22nd bit means the package is overlong.
                        err_next   = 1'b1;
                        state_next = ST_DRAIN;
                    end else begin
                        shreg_next   = shreg_shifted;
                        bit_cnt_next = bit_cnt + ONE_BIT;
                    end
                end else begin
                    bit_cnt_next = '0;
                    if (bit_cnt == LEN_VAL) begin
                        wr_en        = 1'b1;
                        pkt_cnt_next = pkt_cnt + ONE_PKT;
                        state_next   = last_pkt ? ST_DONE : ST_IDLE;
                    end else begin
                        // Package ended early.
                        err_next   = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end

            ST_DRAIN: begin
                // Swallow the tail of an overlong package.
                if (sen) begin
                    bit_cnt_next = '0;
                    state_next   = ST_IDLE;
                end
            end

            ST_DONE: begin
                state_next = ST_DONE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath registers and registered RB2 / status outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            pkt_cnt   <= '0;
            RB2_RW    <= 1'b1;
            RB2_A     <= '0;
            RB2_D     <= '0;
            frame_err <= 1'b0;
            done      <= 1'b0;
        end else begin
            shreg     <= shreg_next;
            bit_cnt   <= bit_cnt_next;
            pkt_cnt   <= pkt_cnt_next;
            frame_err <= err_next;
            // Strobe is low only on the cycle following a write decision.
            RB2_RW    <= ~wr_en;
            if (wr_en) begin
                RB2_A <= shreg[PKT_LEN-1 -: ADDR_W];
                RB2_D <= shreg[DATA_W-1:0];
            end
            // done rises together with the final write strobe and then sticks.
            done <= done | (wr_en & last_pkt);
        end
    end

endmodule

// File: tb/tb_s2_pkt_receiver.sv
// Testbench for s2_pkt_receiver.
module tb_s2_pkt_receiver;

    localparam int ADDR_W  = 3;
    localparam int DATA_W  = 18;
    localparam int NUM_PKT = 8;
    localparam int W       = 1 + ADDR_W + DATA_W;

    logic              clk;
    logic              rst;
    logic              sen;
    logic              sd;
    logic              RB2_RW;
    logic [ADDR_W-1:0] RB2_A;
    logic [DATA_W-1:0] RB2_D;
    logic              frame_err;
    logic              done;
    logic [1:0]        state_dbg;
    logic [3:0]        pkt_cnt_dbg;

    // Scoreboard: {done expected at strobe, addr, data}
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_item;

    int checks;
    int fails;
    int model_cnt;
    int wr_seen;
    int err_seen;
    logic prev_rw;
    logic prev_err;

    s2_pkt_receiver #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .NUM_PKT(NUM_PKT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sen        (sen),
        .sd         (sd),
        .RB2_RW     (RB2_RW),
        .RB2_A      (RB2_A),
        .RB2_D      (RB2_D),
        .frame_err  (frame_err),
        .done       (done),
        .state_dbg  (state_dbg),
        .pkt_cnt_dbg(pkt_cnt_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (RB2_RW === 1'b0) begin
            wr_seen++;
            checks++;
            if (prev_rw === 1'b0) begin
                fails++;
                $display("FAIL strobe_width: RB2_RW low on consecutive cycles, got 0 required 1");
            end
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: got A=%0d D=%h required no write", RB2_A, RB2_D);
            end else begin
                exp_item = exp_q.pop_front();
                if ({done, RB2_A, RB2_D} !== exp_item) begin
                    fails++;
                    $display("FAIL write_data: got done=%b A=%0d D=%h required done=%b A=%0d D=%h",
                             done, RB2_A, RB2_D, exp_item[W-1],
                             exp_item[W-2 -: ADDR_W], exp_item[DATA_W-1:0]);
                end
            end
        end
        if (frame_err === 1'b1) begin
            err_seen++;
            checks++;
            if (prev_err === 1'b1) begin
                fails++;
                $display("FAIL err_width: frame_err high on consecutive cycles, got 1 required 0");
            end
        end
        prev_rw  = RB2_RW;
        prev_err = frame_err;
    end

    // ---------------- driver tasks ----------------
    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        sen = 1'b1;
        sd  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_cnt = 0;
        exp_q.delete();
    endtask

    task automatic send_raw(input logic [22:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clk);
            sen = 1'b0;
            sd  = v[i];
        end
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge clk);
            sen = 1'b1;
            sd  = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic push_exp(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        if (model_cnt < NUM_PKT) begin
            model_cnt++;
            exp_q.push_back({model_cnt == NUM_PKT, addr, data});
        end
    endtask

    task automatic send_pkt(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                            input int gapn);
        push_exp(addr, data);
        send_raw({2'b00, addr, data}, ADDR_W + DATA_W);
        gap(gapn);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        sen = 1'b1;
        sd  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (RB2_RW !== 1'b1) begin fails++; $display("FAIL reset_rw: got %b required 1", RB2_RW); end
        checks++;
        if (RB2_A !== 3'd0) begin fails++; $display("FAIL reset_a: got %0d required 0", RB2_A); end
        checks++;
        if (RB2_D !== 18'd0) begin fails++; $display("FAIL reset_d: got %h required 0", RB2_D); end
        checks++;
        if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b required 0", frame_err); end
        checks++;
        if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b required 0", done); end
        checks++;
        if (pkt_cnt_dbg !== 4'd0) begin fails++; $display("FAIL reset_cnt: got %0d required 0", pkt_cnt_dbg); end
        rst = 1'b1;
        model_cnt = 0;
    endtask

    task automatic test_single_write();
        int w0;
        int e0;
        logic [20:0] pkt;
        do_reset();
        w0  = wr_seen;
        e0  = err_seen;
        pkt = 21'b101_10_1010_0101_1100_0011;
        push_exp(3'd5, 18'h2A5C3);
        send_raw({2'b00, pkt}, 21);
        @(negedge clk);
        sen = 1'b1;
        settle();
        checks++;
        if (RB2_RW !== 1'b0) begin fails++; $display("FAIL single_strobe: got RB2_RW=%b required 0", RB2_RW); end
        checks++;
        if (RB2_A !== 3'd5 || RB2_D !== 18'h2A5C3) begin
            fails++;
            $display("FAIL single_data: got A=%0d D=%h required A=5 D=2a5c3", RB2_A, RB2_D);
        end
        checks++;
        if (frame_err !== 1'b0) begin fails++; $display("FAIL single_err: got %b required 0", frame_err); end
        settle();
        checks++;
        if (RB2_RW !== 1'b1 || RB2_A !== 3'd5 || RB2_D !== 18'h2A5C3) begin
            fails++;
            $display("FAIL single_hold: got RW=%b A=%0d D=%h required RW=1 A=5 D=2a5c3", RB2_RW, RB2_A, RB2_D);
        end
        gap(5);
        settle();
        checks++;
        if (wr_seen - w0 != 1 || err_seen - e0 != 0) begin
            fails++;
            $display("FAIL single_counts: got writes=%0d errs=%0d required 1/0", wr_seen - w0, err_seen - e0);
        end
    endtask

    task automatic test_fill_done();
        int w0;
        do_reset();
        w0 = wr_seen;
        for (int k = 0; k < NUM_PKT; k++) begin
            send_pkt(3'(k), 18'(18'h3FFFF - k), 20);
        end
        settle();
        checks++;
        if (done !== 1'b1 || state_dbg !== 2'd3 || pkt_cnt_dbg !== 4'd8) begin
            fails++;
            $display("FAIL fill_done: got done=%b state=%0d cnt=%0d required 1/3/8", done, state_dbg, pkt_cnt_dbg);
        end
        checks++;
        if (wr_seen - w0 != NUM_PKT || exp_q.size() != 0) begin
            fails++;
            $display("FAIL fill_writes: got %0d writes, %0d pending required 8/0", wr_seen - w0, exp_q.size());
        end
        send_pkt(3'd3, 18'h11111, 10);
        settle();
        checks++;
        if (wr_seen - w0 != NUM_PKT || done !== 1'b1) begin
            fails++;
            $display("FAIL ninth_pkt: got %0d writes done=%b required 8 writes done=1", wr_seen - w0, done);
        end
    endtask

    task automatic test_short_pkt();
        int w0;
        int e0;
        do_reset();
        w0 = wr_seen;
        e0 = err_seen;
        send_raw(23'($urandom()), 19);
        @(negedge clk);
        sen = 1'b1;
        settle();
        checks++;
        if (frame_err !== 1'b1 || RB2_RW !== 1'b1) begin
            fails++;
            $display("FAIL short_err: got err=%b RW=%b required err=1 RW=1", frame_err, RB2_RW);
        end
        gap(4);
        send_pkt(3'd2, 18'h00001, 5);
        settle();
        checks++;
        if (err_seen - e0 != 1 || wr_seen - w0 != 1 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL short_counts: got errs=%0d writes=%0d pending=%0d required 1/1/0",
                     err_seen - e0, wr_seen - w0, exp_q.size());
        end
    endtask

    task automatic test_long_pkt();
        int w0;
        int e0;
        do_reset();
        w0 = wr_seen;
        e0 = err_seen;
        send_raw(23'($urandom()), 21);
        @(negedge clk);
        sen = 1'b0;
        sd  = 1'($urandom_range(0, 1));
        settle();
        checks++;
        if (frame_err !== 1'b1 || RB2_RW !== 1'b1) begin
            fails++;
            $display("FAIL long_err: got err=%b RW=%b required err=1 RW=1", frame_err, RB2_RW);
        end
        @(negedge clk);
        sen = 1'b0;
        sd  = 1'($urandom_range(0, 1));
        gap(4);
        send_pkt(3'd3, 18'($urandom()), 5);
        settle();
        checks++;
        if (err_seen - e0 != 1 || wr_seen - w0 != 1 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL long_counts: got errs=%0d writes=%0d pending=%0d required 1/1/0",
                     err_seen - e0, wr_seen - w0, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int w0;
        do_reset();
        w0 = wr_seen;
        send_pkt(3'd1, 18'h12345, 1);
        send_pkt(3'd6, 18'h0ABCD, 1);
        send_raw(23'($urandom()), 10);
        @(negedge clk);
        rst = 1'b0;
        sen = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        sen = 1'b1;
        model_cnt = 0;
        settle();
        checks++;
        if (wr_seen - w0 != 2 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL b2b_writes: got %0d writes %0d pending required 2/0", wr_seen - w0, exp_q.size());
        end
        checks++;
        if (RB2_RW !== 1'b1 || RB2_A !== 3'd0 || RB2_D !== 18'd0 || frame_err !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL b2b_reset_out: got RW=%b A=%0d D=%h err=%b done=%b required 1/0/0/0/0",
                     RB2_RW, RB2_A, RB2_D, frame_err, done);
        end
        checks++;
        if (pkt_cnt_dbg !== 4'd0 || state_dbg !== 2'd0) begin
            fails++;
            $display("FAIL b2b_reset_state: got cnt=%0d state=%0d required 0/0", pkt_cnt_dbg, state_dbg);
        end
    endtask

    task automatic test_random_pkts();
        int w0;
        do_reset();
        w0 = wr_seen;
        for (int k = 0; k < NUM_PKT + 2; k++) begin
            send_pkt(3'($urandom_range(0, 7)), 18'($urandom()), $urandom_range(1, 3));
        end
        gap(3);
        settle();
        checks++;
        if (wr_seen - w0 != NUM_PKT || exp_q.size() != 0 || done !== 1'b1) begin
            fails++;
            $display("FAIL random_pkts: got %0d writes %0d pending done=%b required 8/0/1",
                     wr_seen - w0, exp_q.size(), done);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks    = 0;
        fails     = 0;
        model_cnt = 0;
        wr_seen   = 0;
        err_seen  = 0;
        prev_rw   = 1'b1;
        prev_err  = 1'b0;
        rst       = 1'b1;
        sen       = 1'b1;
        sd        = 1'b0;

        test_reset();
        test_single_write();
        test_fill_done();
        test_short_pkt();
        test_long_pkt();
        test_back_to_back();
        test_random_pkts();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
